// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: master id type,
// arbiter state encoding and a one-hot helper.
package bus_pkg;

    localparam int BUS_NM      = 4;
    localparam int BUS_BURST_W = 8;

    typedef logic [1:0] bus_mid_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic logic [BUS_NM-1:0] bus_onehot(input bus_mid_t id);
        logic [BUS_NM-1:0] one;
        one = {{(BUS_NM-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way rotating priority encoder: the first set request
// at or after the start index, wrapping, wins.
module rr_pick
    import bus_pkg::*;
(
    input  logic [BUS_NM-1:0] req,
    input  bus_mid_t          start,
    output logic              valid,
    output bus_mid_t          id
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the block leaves it unassigned (no latch).
        valid = 1'b0;
        id    = start;
        for (int i = 0; i < BUS_NM; i++) begin
            bus_mid_t idx;
            idx = start + bus_mid_t'(i);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbit_rr.sv
// Four-master round-robin arbiter with registered one-hot grants held for the
// owner's request. Optional forced release: define BUS_ARBIT_BURST_LIMIT_EN.
module bus_arbit_rr
    import bus_pkg::*;
#(
    parameter int NM        = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [3:0]             req,
    output logic [3:0]             grant,
    output bus_mid_t               grant_id,
    output logic                   bus_busy,
    output logic [BUS_BURST_W-1:0] burst_cnt
);

    if (NM != BUS_NM) begin : g_bad_nm
        $error("bus_arbit_rr supports exactly 4 masters");
    end
    if (MAX_BURST < 2 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("bus_arbit_rr MAX_BURST must be within 2..256");
    end

    localparam logic [3:0] REQ_MASK = 4'((1 << NM) - 1);

`ifdef BUS_ARBIT_BURST_LIMIT_EN
    localparam logic [BUS_BURST_W-1:0] BURST_CAP = BUS_BURST_W'(MAX_BURST - 1);
`else
    localparam logic [BUS_BURST_W-1:0] BURST_CAP = {BUS_BURST_W{1'b1}};
`endif

    arb_state_t             state, state_nxt;
    logic [3:0]             grant_nxt;
    bus_mid_t               id_nxt;
    logic [BUS_BURST_W-1:0] cnt_nxt;

    logic [3:0] req_eff;
    logic       pick_valid;
    bus_mid_t   pick_id;
    logic       owner_req;
    logic       force_rel;

    assign req_eff   = req & REQ_MASK;
    assign owner_req = req_eff[grant_id];

`ifdef BUS_ARBIT_BURST_LIMIT_EN
    logic rivals;
    assign rivals    = |(req_eff & ~bus_onehot(grant_id));
    assign force_rel = (burst_cnt == BURST_CAP) && rivals;
`else
    assign force_rel = 1'b0;
`endif

    // Search starts just past the last owner, so a releasing master is
    // considered last among those waiting.
    rr_pick u_pick (
        .req   (req_eff),
        .start (grant_id + bus_mid_t'(1)),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        id_nxt    = grant_id;
        cnt_nxt   = burst_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ARB_OWNED;
                    grant_nxt = bus_onehot(pick_id);
                    id_nxt    = pick_id;
                    cnt_nxt   = '0;
                end
            end
            ARB_OWNED: begin
                if (owner_req && !force_rel) begin
                    if (burst_cnt != BURST_CAP) begin
                        cnt_nxt = burst_cnt + 1'b1;
                    end
                end else if (pick_valid) begin
                    // Direct handover: the next owner is granted on this edge.
                    grant_nxt = bus_onehot(pick_id);
                    id_nxt    = pick_id;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            grant_id  <= bus_mid_t'(3);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_id  <= id_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    assign bus_busy = |grant;

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Self-checking bench for bus_arbit_rr: directed test-plan cases plus random
// requests compared against a behavioural round-robin model.
module tb_bus_arbit_rr;

`ifdef BUS_ARBIT_BURST_LIMIT_EN
    localparam int  MB  = 4;
    localparam bit  LIM = 1'b1;
`else
    localparam int  MB  = 16;
    localparam bit  LIM = 1'b0;
`endif
    localparam int CAP = LIM ? MB - 1 : 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic [7:0] burst_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    bit m_owned;
    int m_last;
    int m_cnt;

    // fairness bookkeeping
    int         skip [4];
    int         max_skip = 0;
    logic [3:0] prev_grant;

    bus_arbit_rr #(.NM(4), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .grant     (grant),
        .grant_id  (grant_id),
        .bus_busy  (bus_busy),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owned = 1'b0;
        m_last  = 3;
        m_cnt   = 0;
        for (int i = 0; i < 4; i++) skip[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int pick;
        int o;
        logic [3:0] others;
        pick = -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (pick < 0 && r[idx]) pick = idx;
        end
        if (!m_owned) begin
            if (pick >= 0) begin
                m_owned = 1'b1;
                m_last  = pick;
                m_cnt   = 0;
            end
        end else begin
            o      = m_last;
            others = r & ~(4'b0001 << o);
            if (r[o]) begin
                if (LIM && m_cnt == MB - 1 && others != 0) begin
                    m_last = pick;
                    m_cnt  = 0;
                end else if (m_cnt < CAP) begin
                    m_cnt = m_cnt + 1;
                end
            end else if (pick >= 0) begin
                m_last = pick;
                m_cnt  = 0;
            end else begin
                m_owned = 1'b0;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = m_owned ? (4'b0001 << m_last) : 4'b0000;
        check("model_grant", 32'(grant), 32'(eg));
        check("model_grant_id", 32'(grant_id), 32'(m_last));
        check("model_burst_cnt", 32'(burst_cnt), 32'(m_cnt));
        check("model_bus_busy", 32'(bus_busy), 32'(m_owned));
    endtask

    // Drive req at the falling edge, step the model at the rising edge,
    // then compare 1 time unit later.
    task automatic tick(input logic [3:0] r);
        @(negedge clk);
        req        = r;
        prev_grant = grant;
        @(posedge clk);
        model_step(r);
        #1;
        check_model();
        if (grant != 4'b0000 && grant != prev_grant) begin
            for (int i = 0; i < 4; i++) begin
                if (grant[i])  skip[i] = 0;
                else if (r[i]) skip[i]++;
                else           skip[i] = 0;
                if (skip[i] > max_skip) max_skip = skip[i];
            end
        end else begin
            for (int i = 0; i < 4; i++) if (!r[i] || grant[i]) skip[i] = 0;
        end
    endtask

    initial begin
        logic [3:0] rot [4];
        logic [3:0] r;
        rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001;

        reset_n = 1'b0;
        req     = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h3);
        check("rst_bus_busy", 32'(bus_busy), 32'h0);
        check("rst_burst_cnt", 32'(burst_cnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // all request, one-cycle releases rotate the grant
        tick(4'b1111);
        check("all_req_first", 32'(grant), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick(4'b1111 & ~grant);
            check("rotate_grant", 32'(grant), 32'(rot[i]));
            check("rotate_no_gap", 32'(bus_busy), 32'h1);
        end
        tick(4'b0000);
        check("idle_after_rotate", 32'(grant), 32'h0);

        // single master hold then release
        for (int k = 0; k < 5; k++) begin
            tick(4'b0100);
            check("hold_grant", 32'(grant), 32'h4);
            check("hold_burst", 32'(burst_cnt), 32'((k < CAP) ? k : CAP));
        end
        tick(4'b0000);
        check("release_idle", 32'(grant), 32'h0);
        check("release_keep_id", 32'(grant_id), 32'h2);

        // owner 1 releases with 0 and 3 waiting -> 3
        tick(4'b0010);
        check("own1_grant", 32'(grant), 32'h2);
        tick(4'b1001);
        check("rr_skip_to_3", 32'(grant), 32'h8);
        tick(4'b0000);

`ifdef BUS_ARBIT_BURST_LIMIT_EN
        tick(4'b0001);
        check("lim_start", 32'(grant), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            tick(4'b0101);
            check("lim_held", 32'(grant), 32'h1);
            check("lim_cnt", 32'(burst_cnt), 32'(k));
        end
        tick(4'b0101);
        check("lim_revoke", 32'(grant), 32'h4);
        check("lim_revoke_cnt", 32'(burst_cnt), 32'h0);
        tick(4'b0000);
        for (int k = 0; k < 6; k++) begin
            tick(4'b0001);
            check("lim_alone_grant", 32'(grant), 32'h1);
            check("lim_alone_cnt", 32'(burst_cnt), 32'((k < 3) ? k : 3));
        end
        tick(4'b0000);
`endif

        // asynchronous reset while owned
        tick(4'b1111);
        tick(4'b1111);
        check("pre_rst_busy", 32'(bus_busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_id", 32'(grant_id), 32'h3);
        check("async_rst_busy", 32'(bus_busy), 32'h0);
        check("async_rst_cnt", 32'(burst_cnt), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick(4'b1010);
        check("post_rst_grant", 32'(grant), 32'h2);

        // random traffic
        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            tick(r);
            check("rand_onehot0", 32'($onehot0(grant)), 32'h1);
            check("rand_busy_or", 32'(bus_busy), 32'(|grant));
        end
        check("fair_max_skip_le3", 32'(max_skip <= 3), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbit_rr.md
# bus_arbit_rr

Four-master round-robin bus arbiter with registered one-hot grants, grant hold for the duration of a master's request, and an optional burst-length limit. It replaces fixed-priority arbitration in front of the shared-bus master-side muxes. `grant_id` drives the mux select directly, and `grant` returns to each master as its grant line.

## Interface
- `NM`, 4: number of masters; fixed at 4 in this revision.
- `MAX_BURST`, 16: maximum consecutive granted cycles while another master is waiting; legal range 2..256. Only used with the limit compiled in.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request per master; the master holds it high for as long as it needs the bus.
- `grant`  output  4  registered one-hot grant; all zero when idle.
- `grant_id`  output  2  index of the granted master. Holds the last owner when idle; mux select.
- `bus_busy`  output  1  high when any grant is asserted (equals `|grant`).
- `burst_cnt`  output  8  cycles the current owner has held the bus, minus 1; 0 when idle.

## Operation
- State machine has two states:
  - IDLE: no grant.
  - OWNED: exactly one grant bit high.
- Reset values: state IDLE, `grant`=0, `grant_id`=3 (last-owner pointer), `bus_busy`=0, `burst_cnt`=0.
- Round-robin pick: search `req` starting at index `last+1` mod 4 and wrapping; the first set bit wins. `last` is `grant_id`.
- In IDLE:
  - If any `req` is high: move to OWNED, grant the picked master, set `burst_cnt` to 0.
  - Otherwise stay in IDLE.
- In OWNED, with owner `o`:
  - `req[o]` high and no forced release: keep the grant and increment `burst_cnt`.
  - `req[o]` low and another request present: hand over in the same edge to the pick computed from `o+1`. No dead cycle between owners; `burst_cnt` resets to 0.
  - `req[o]` low and no other request: go to IDLE, clear `grant`, set `burst_cnt` to 0, keep `grant_id`.
- A master re-requesting right after releasing competes normally. It is served last among the waiting masters, because the search starts after it.
- The grant is never revoked while the owner's `req` is high, except by the burst limit (see Configuration).
- Reset asserted mid-ownership: all outputs go to their reset values immediately (asynchronously). After release, arbitration restarts with master 0 highest.
- `req` bits for masters at or beyond `NM` are ignored.

## Timing
- Grant latency: `req` sampled high at edge N gives `grant` high after edge N (one cycle). This holds in both IDLE and handover.
- Release latency: `req[o]` low at edge N removes `grant[o]` after edge N.
- All outputs are registered; there is no combinational path from `req` to any output.
- `burst_cnt` saturates at 255 (without the limit) or at `MAX_BURST-1` (with the limit).

## Configuration
- Macro: `BUS_ARBIT_BURST_LIMIT_EN`.
- Defined:
  - Condition: owner is in OWNED, `burst_cnt` equals `MAX_BURST-1`, and at least one other `req` is high.
  - Action: at the next edge the grant is forcibly handed to the round-robin pick from `o+1`, and `burst_cnt` resets to 0.
  - If no competitor is waiting, the owner keeps the bus and `burst_cnt` stays at `MAX_BURST-1`.
  - The revoked master must tolerate losing its grant while still requesting, and re-arbitrates normally.
- Undefined: no forced release, so an owner keeps the bus for as long as `req[o]` stays high. `MAX_BURST` is unused.

## Structure
- Shared package `bus_pkg`:
  - `BUS_NM` = 4.
  - typedef `bus_mid_t` (2-bit master id).
  - typedef `arb_state_t` {ARB_IDLE, ARB_OWNED}.
  - `BUS_BURST_W` = 8.
- One sub-module, `rr_pick`: combinational 4-way rotating priority encoder.
  - Inputs: `req[3:0]`, start index.
  - Outputs: `valid`, picked id.
  - The top instantiates it once; the input is `last+1`.

## Test plan
- Reset, then `req`=4'b1111 → `grant`=0001 one cycle later. Each one-cycle release then hands over in order 0010, 0100, 1000, 0001, with no zero cycle between owners.
- `req`=4'b0100 only, held 5 cycles, then dropped → `grant`=0100 for 5 cycles, `burst_cnt` counts 0..4, then IDLE with `grant_id`=2.
- Owner 1 releases while `req`=4'b1001 → next grant is master 3, not master 0.
- With `BUS_ARBIT_BURST_LIMIT_EN` and `MAX_BURST`=4: master 0 holds `req`, master 2 requests at cycle 1 → master 0 is revoked after 4 granted cycles and `grant`=0100. With no competitor, master 0 stays granted and `burst_cnt` sticks at 3.
- Assert `reset_n`=0 mid-OWNED → `grant`=0, `grant_id`=3, `bus_busy`=0 immediately. After release with `req`=4'b1010, the grant goes to master 1.
- Random `req` for 10,000 cycles → `grant` is always one-hot or zero, `bus_busy` equals `|grant`, and no waiting master is skipped more than 3 handovers.
